// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state and line type for the 2-way cache controller.
package cache_pkg;
    localparam int SETS      = 64;
    localparam int ADDR_BASE = 1024;
    localparam int TAG_W     = 10;
    localparam int IDX_W     = $clog2(SETS);
    localparam int WSEL_BIT  = 2;
    localparam int IDX_LSB   = 3;
    localparam int TAG_LSB   = IDX_LSB + IDX_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } line_t;
endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if: pipeline-side and SRAM-side bus of the cache.
// Defining CACHE_STATS_EN adds the hit/miss counter outputs.
interface cache_controller_if;
    logic        MEM_R_EN, MEM_W_EN, ready;
    logic [31:0] address, wdata, rdata;
    logic [31:0] sram_address, sram_wdata;
    logic        sram_rd_en, sram_wr_en, sram_ready;
    logic [63:0] sram_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    modport slave(
        input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_rd_en, sram_wr_en, hit_count, miss_count
    );
    modport master(
        output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_rd_en, sram_wr_en, hit_count, miss_count
    );
`else
    modport slave(
        input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_rd_en, sram_wr_en
    );
    modport master(
        output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_rd_en, sram_wr_en
    );
`endif
endinterface

// File: rtl/cache_storage.sv
// cache_storage: two ways of valid/tag/data lines plus one LRU bit per set,
// with combinational lookup and fill / invalidate / LRU-update ports.
module cache_storage
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [TAG_W-1:0] tag,
    output logic             hit0,
    output logic             hit1,
    output logic [63:0]      data0,
    output logic [63:0]      data1,
    output logic             victim,
    input  logic             fill_en,
    input  logic             fill_way,
    input  logic [63:0]      fill_data,
    input  logic             inv_en,
    input  logic             inv_way,
    input  logic             lru_en,
    input  logic             lru_way
);
    line_t           line_q [2][SETS];
    line_t           line_d [2][SETS];
    logic [SETS-1:0] lru_q, lru_d;
    line_t           l0, l1;

    assign l0     = line_q[0][idx];
    assign l1     = line_q[1][idx];
    assign hit0   = l0.valid && l0.tag == tag;
    assign hit1   = l1.valid && l1.tag == tag;
    assign data0  = l0.data;
    assign data1  = l1.data;
    // lru bit names the least recently used way, which is also the victim when both are valid
    assign victim = !l0.valid ? 1'b0 : !l1.valid ? 1'b1 : lru_q[idx];

    always_comb begin
        line_d = line_q;
        lru_d  = lru_q;
        if (fill_en) line_d[fill_way][idx] = '{valid: 1'b1, tag: tag, data: fill_data};
        if (inv_en) line_d[inv_way][idx].valid = 1'b0;
        if (lru_en) lru_d[idx] = ~lru_way;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < SETS; s++)
                    line_q[w][s] <= '0;
            lru_q <= '0;
        end else begin
            line_q <= line_d;
            lru_q  <= lru_d;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, read-allocate cache FSM.
// Defining CACHE_STATS_EN adds saturating read hit/miss counters.
module cache_controller
    import cache_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    cache_controller_if.slave  bus
);
    state_t      state_q, state_d;
    logic [31:0] a;
    logic        hit0, hit1, hit, victim, rd_hit, fill_en;
    logic        inv_en, inv_way, lru_en, lru_way;
    logic [63:0] data0, data1, hit_line;
    logic        unused_bits;

    assign a           = bus.address - 32'(ADDR_BASE);
    assign unused_bits = ^{a[31:TAG_LSB+TAG_W], a[1:0]};
    assign hit         = hit0 | hit1;
    assign hit_line    = hit0 ? data0 : data1;
    assign rd_hit      = state_q == IDLE && bus.MEM_R_EN && !bus.MEM_W_EN && hit;
    assign fill_en     = state_q == READ_MISS && bus.sram_ready;

    cache_storage u_storage (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (a[TAG_LSB-1:IDX_LSB]),
        .tag      (a[TAG_LSB+TAG_W-1:TAG_LSB]),
        .hit0     (hit0),
        .hit1     (hit1),
        .data0    (data0),
        .data1    (data1),
        .victim   (victim),
        .fill_en  (fill_en),
        .fill_way (victim),
        .fill_data(bus.sram_rdata),
        .inv_en   (inv_en),
        .inv_way  (inv_way),
        .lru_en   (lru_en),
        .lru_way  (lru_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (bus.MEM_W_EN ? WRITE : (bus.MEM_R_EN && !hit) ? READ_MISS : IDLE)
                                  : (bus.sram_ready ? IDLE : state_q);
    end

    // SRAM enables are gated by rst_n so they drop the instant reset asserts
    always_comb begin
        bus.ready      = state_q == IDLE ? !(bus.MEM_W_EN || (bus.MEM_R_EN && !hit)) : bus.sram_ready;
        bus.sram_rd_en = rst_n && (state_q == READ_MISS ||
                                   (state_q == IDLE && !bus.MEM_W_EN && bus.MEM_R_EN && !hit));
        bus.sram_wr_en = rst_n && (state_q == WRITE || (state_q == IDLE && bus.MEM_W_EN));
        bus.rdata      = rd_hit  ? (a[WSEL_BIT] ? hit_line[63:32] : hit_line[31:0])
                       : fill_en ? (a[WSEL_BIT] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0])
                       : '0;
        inv_en         = state_q == WRITE && bus.sram_ready && hit;
        inv_way        = !hit0;
        lru_en         = rd_hit || fill_en;
        lru_way        = fill_en ? victim : !hit0;
    end

    assign bus.sram_address = bus.address;
    assign bus.sram_wdata   = bus.wdata;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + 32'(rd_hit && hit_count_q != '1);
        miss_count_d = miss_count_q + 32'(fill_en && miss_count_q != '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and random loads/stores against a recency-list cache model
// and a word-addressable memory model.
module tb_cache_controller;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if bus();
    cache_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    int hits = 0;
    int misses = 0;
    logic [63:0] mem [int];
    int rec [SETS][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ev);
        total++;
        assert (obs === ev) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ev);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] line_data(input int ln);
        if (!mem.exists(ln)) mem[ln] = {$urandom, $urandom};
        return mem[ln];
    endfunction

    function automatic int find(input int s, input int t);
        foreach (rec[s][i]) if (rec[s][i] == t) return i;
        return -1;
    endfunction

    task automatic check_stats;
`ifdef CACHE_STATS_EN
        chk("hit_count", 64'(bus.hit_count), 64'(hits));
        chk("miss_count", 64'(bus.miss_count), 64'(misses));
`endif
    endtask

    task automatic do_read(input logic [31:0] addr, input int lat);
        int off = int'(addr) - ADDR_BASE;
        int s = (off >> 3) % SETS;
        int t = off >> 9;
        int i = find(s, t);
        logic [63:0] d = line_data(off >> 3);
        logic [31:0] ev = ((off >> 2) & 1) != 0 ? d[63:32] : d[31:0];
        bus.MEM_R_EN = 1'b1;
        bus.MEM_W_EN = 1'b0;
        bus.address = addr;
        #4;
        if (i >= 0) begin
            chk("hit_ready", 64'(bus.ready), 64'd1);
            chk("hit_rdata", 64'(bus.rdata), 64'(ev));
            chk("hit_rd_en", 64'(bus.sram_rd_en), 64'd0);
            rec[s].delete(i);
            rec[s].push_back(t);
            hits++;
            step;
        end else begin
            chk("miss_ready", 64'(bus.ready), 64'd0);
            chk("miss_rd_en", 64'(bus.sram_rd_en), 64'd1);
            step;
            repeat (lat) begin
                #4;
                chk("wait_ready", 64'(bus.ready), 64'd0);
                chk("wait_rd_en", 64'(bus.sram_rd_en), 64'd1);
                step;
            end
            bus.sram_ready = 1'b1;
            bus.sram_rdata = d;
            #4;
            chk("fill_ready", 64'(bus.ready), 64'd1);
            chk("fill_rdata", 64'(bus.rdata), 64'(ev));
            step;
            bus.sram_ready = 1'b0;
            if (rec[s].size() == 2) void'(rec[s].pop_front());
            rec[s].push_back(t);
            misses++;
        end
        bus.MEM_R_EN = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat, input logic rd_too);
        int off = int'(addr) - ADDR_BASE;
        int s = (off >> 3) % SETS;
        int i = find(s, off >> 9);
        logic [63:0] d = line_data(off >> 3);
        bus.MEM_W_EN = 1'b1;
        bus.MEM_R_EN = rd_too;
        bus.address = addr;
        bus.wdata = data;
        #4;
        chk("wr_ready", 64'(bus.ready), 64'd0);
        chk("wr_en", 64'(bus.sram_wr_en), 64'd1);
        chk("wr_rd_en", 64'(bus.sram_rd_en), 64'd0);
        chk("wr_wdata", 64'(bus.sram_wdata), 64'(data));
        chk("wr_address", 64'(bus.sram_address), 64'(addr));
        step;
        bus.MEM_R_EN = 1'b0;
        repeat (lat) begin
            #4;
            chk("wr_wait_ready", 64'(bus.ready), 64'd0);
            chk("wr_wait_en", 64'(bus.sram_wr_en), 64'd1);
            step;
        end
        bus.sram_ready = 1'b1;
        #4;
        chk("wr_done_ready", 64'(bus.ready), 64'd1);
        step;
        bus.sram_ready = 1'b0;
        bus.MEM_W_EN = 1'b0;
        if (((off >> 2) & 1) != 0) d[63:32] = data;
        else d[31:0] = data;
        mem[off >> 3] = d;
        if (i >= 0) rec[s].delete(i);
    endtask

    initial begin
        logic [31:0] x;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        bus.address = 32'd1024;
        bus.wdata = '0;
        bus.sram_rdata = '0;
        bus.sram_ready = 1'b0;
        step;
        chk("rst_rd_en", 64'(bus.sram_rd_en), 64'd0);
        chk("rst_wr_en", 64'(bus.sram_wr_en), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        step;
        rst_n = 1'b1;
        #4;
        chk("idle_ready", 64'(bus.ready), 64'd1);
        chk("idle_rd_en", 64'(bus.sram_rd_en), 64'd0);
        chk("idle_wr_en", 64'(bus.sram_wr_en), 64'd0);
        check_stats;
        step;

        mem[0] = 64'h0000_BBBB_0000_AAAA;
        do_read(32'd1024, 3);
        do_read(32'd1028, 0);

        do_read(32'd1536, 1);
        do_read(32'd1024, 0);
        do_read(32'd2048, 2);
        do_read(32'd1024, 0);
        do_read(32'd1536, 0);

        do_write(32'd1024, 32'hDEAD_BEEF, 2, 1'b0);
        do_read(32'd1024, 1);
        check_stats;

        x = 32'd1024 + 32'd24;
        bus.MEM_R_EN = 1'b1;
        bus.address = x;
        #4;
        chk("drop_rd_en", 64'(bus.sram_rd_en), 64'd1);
        step;
        bus.MEM_R_EN = 1'b0;
        #4;
        chk("held_rd_en", 64'(bus.sram_rd_en), 64'd1);
        step;
        bus.sram_ready = 1'b1;
        bus.sram_rdata = line_data(3);
        step;
        bus.sram_ready = 1'b0;
        rec[3].push_back(0);
        misses++;
        do_read(x, 0);

        bus.MEM_R_EN = 1'b1;
        bus.address = 32'd1024 + 32'd40;
        step;
        step;
        step;
        rst_n = 1'b0;
        #1;
        chk("reset_drop_rd_en", 64'(bus.sram_rd_en), 64'd0);
        bus.MEM_R_EN = 1'b0;
        foreach (rec[s]) rec[s].delete();
        hits = 0;
        misses = 0;
        step;
        rst_n = 1'b1;
        #4;
        check_stats;
        step;
        do_read(32'd1024, 0);

        for (int n = 0; n < 150; n++) begin
            x = 32'd1024 + 32'($urandom_range(0, 3) * 512 + $urandom_range(0, 2) * 8 + $urandom_range(0, 1) * 4);
            if ($urandom_range(0, 9) < 7) do_read(x, $urandom_range(0, 3));
            else do_write(x, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step;
        end
        #4;
        check_stats;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
